multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
Sequencing FSM for the multicycle RV32I core. One shared instruction/data memory and one ALU are reused across several cycles per instruction. Sits between the instruction register (opcode/funct fields) and the datapath muxes, enables and memory port, replacing the combinational control_unit. Adds a req/ready memory handshake, illegal-opcode trap and retired-instruction counter.

Parameters:
INSTRET_W, 32, width of retired-instruction counter

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
opcode  input  7  IR[6:0]
funct3  input  3  IR[14:12]
funct7  input  7  IR[31:25]
alu_eq  input  1  ALU a==b flag
mem_ready  input  1  memory completes current request this cycle
mem_req  output  1  memory request, held until mem_ready
mem_write  output  1  store qualifier, valid with mem_req
adr_src  output  1  0=PC, 1=ALUOut register
ir_write  output  1  latch IR and old_pc
pc_write  output  1  update PC from result mux
reg_write  output  1  register file write enable
alu_src_a  output  2  0=PC, 1=old_pc, 2=rs1
alu_src_b  output  2  0=rs2, 1=imm_ext, 2=const 4
alu_op  output  4  alu_op_t
result_src  output  2  0=ALUOut reg, 1=mem data reg, 2=ALU result
imm_sel  output  3  imm_sel_t: I=0, SHAMT=1, S=2, U=3, B=4, J=5
illegal  output  1  sticky unsupported-opcode flag
state_check  output  4  current state encoding
instret  output  INSTRET_W  retired instruction count

Behaviour:
- Reset: state FETCH, illegal=0, instret=0. Every output defaults to 0 (alu_op=ADD) unless listed for a state.
- FETCH(0): mem_req=1, adr_src=0, alu_src_a=0, alu_src_b=2, ADD, result_src=2. If mem_ready: ir_write=1, pc_write=1, go to DECODE; else stay with outputs stable.
- DECODE(1): alu_src_a=1, alu_src_b=1, ADD; imm_sel=J if opcode JAL, else B (target latched in ALUOut). Next: LW/SW->MEM_ADDR, R-type->EXEC_R, I-ALU->EXEC_I, LUI->LUI, JAL->JAL, JALR->JALR, BEQ-class->BRANCH, other->TRAP.
- MEM_ADDR(2): alu_src_a=2, alu_src_b=1, ADD, imm_sel=I (LW) or S (SW). Next MEM_READ or MEM_WRITE.
- MEM_READ(3): mem_req=1, adr_src=1; on mem_ready -> MEM_WB.
- MEM_WB(4): result_src=1, reg_write=1 -> FETCH.
- MEM_WRITE(5): mem_req=1, mem_write=1, adr_src=1; on mem_ready -> FETCH.
- EXEC_R(6): alu_src_a=2, alu_src_b=0, alu_op from decoder -> ALU_WB.
- EXEC_I(7): alu_src_a=2, alu_src_b=1, imm_sel=SHAMT for funct3 001/101 else I -> ALU_WB.
- ALU_WB(8): result_src=0, reg_write=1 -> FETCH.
- JAL(9): pc_write=1, result_src=0; alu_src_a=1, alu_src_b=2, ADD (link to ALUOut) -> ALU_WB.
- BRANCH(10): alu_src_a=2, alu_src_b=0, SUB; result_src=0; pc_write = (funct3==000 & alu_eq) | (funct3==001 & !alu_eq); other funct3 never taken -> FETCH.
- LUI(11): alu_src_b=1, imm_sel=U, BPASS -> ALU_WB.
- JALR(12): alu_src_a=2, alu_src_b=1, imm_sel=I, ADD, result_src=2, pc_write=1 -> JALR_LINK.
- JALR_LINK(13): alu_src_a=1, alu_src_b=2, ADD, result_src=2, reg_write=1 -> FETCH.
- TRAP(14): illegal=1, all enables 0; remain until reset.
- ALU decode (R/I): 000 ADD (SUB if R and funct7=0100000), 001 SLL, 010/011 SLT, 100 XOR, 101 SRL (SRA if funct7=0100000), 110 OR, 111 AND.
- mem_ready ignored when mem_req=0. mem_req, mem_write, adr_src and alu controls stay stable while waiting.
- instret increments by 1 on each transition into FETCH from any non-FETCH state, with 2^INSTRET_W wrap-around. TRAP never increments.
- Reset mid-operation (e.g. waiting in MEM_WRITE): next cycle FETCH, no instret increment. Reset dominates mem_ready.
- CPI without wait states: LW 5, SW 4, R/I/LUI 4, JAL 4, JALR 4, branch 3.

Decomposition:
- rv32i_pkg: alu_op_t, opcode_t, imm_sel_t (extends the existing sign_extend_t values), mc_state_t, alu_src_a_t, alu_src_b_t, result_src_t.
- Sub-module mc_alu_decoder: combinational funct3/funct7/is_rtype -> alu_op.

Test Plan:
- Reset, then ADDI x1,x0,5 with mem_ready tied 1 -> states 0,1,7,8,0; reg_write only in ALU_WB; instret=1 after 4 cycles.
- LW with mem_ready low 3 cycles in MEM_READ -> mem_req/adr_src=1 held 4 cycles; MEM_WB has result_src=1; instret=1 after 8 cycles.
- BEQ alu_eq=1 then BNE alu_eq=1 -> pc_write=1 in first BRANCH, 0 in second; both return to FETCH.
- JALR -> pc_write in JALR with result_src=2; reg_write in JALR_LINK with alu_src_a=1, alu_src_b=2.
- opcode 7'b1111111 -> TRAP, illegal=1 held for 10 cycles, instret frozen; reset clears illegal.
- SW with reset asserted while waiting in MEM_WRITE -> next state FETCH, mem_write=0, instret unchanged.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I control encodings for the multicycle core: opcodes, ALU ops,
// immediate formats, controller states and datapath mux selects.
package rv32i_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SRL   = 4'd5,
        ALU_SRA   = 4'd6,
        ALU_OR    = 4'd7,
        ALU_AND   = 4'd8,
        ALU_BPASS = 4'd9
    } alu_op_t;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_R      = 7'b0110011,
        OP_I      = 7'b0010011,
        OP_LUI    = 7'b0110111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011
    } opcode_t;

    // First three values match the legacy sign-extender selects.
    typedef enum logic [2:0] {
        IMM_I     = 3'd0,
        IMM_SHAMT = 3'd1,
        IMM_S     = 3'd2,
        IMM_U     = 3'd3,
        IMM_B     = 3'd4,
        IMM_J     = 3'd5
    } imm_sel_t;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_JAL       = 4'd9,
        S_BRANCH    = 4'd10,
        S_LUI       = 4'd11,
        S_JALR      = 4'd12,
        S_JALR_LINK = 4'd13,
        S_TRAP      = 4'd14
    } mc_state_t;

    typedef enum logic [1:0] {
        SRC_A_PC     = 2'd0,
        SRC_A_OLD_PC = 2'd1,
        SRC_A_RS1    = 2'd2
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'd0,
        SRC_B_IMM  = 2'd1,
        SRC_B_FOUR = 2'd2
    } alu_src_b_t;

    typedef enum logic [1:0] {
        RES_ALUOUT  = 2'd0,
        RES_MEMDATA = 2'd1,
        RES_ALU     = 2'd2
    } result_src_t;

    localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

endpackage

// File: rtl/mc_alu_decoder.sv
// Maps funct3/funct7 of R-type and I-type ALU instructions onto an ALU operation.
module mc_alu_decoder
    import rv32i_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       is_rtype,
    output logic [3:0] alu_op
);

    logic alt;

    assign alt = (funct7 == FUNCT7_ALT);

    // SUB only exists for R-type; SRAI shares the funct7 marker with SRA.
    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            3'b000: alu_op = (is_rtype && alt) ? ALU_SUB : ALU_ADD;
            3'b001: alu_op = ALU_SLL;
            3'b010: alu_op = ALU_SLT;
            3'b011: alu_op = ALU_SLT;
            3'b100: alu_op = ALU_XOR;
            3'b101: alu_op = alt ? ALU_SRA : ALU_SRL;
            3'b110: alu_op = ALU_OR;
            3'b111: alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencer: walks each instruction through shared-memory and
// shared-ALU steps, handshakes with memory, traps unknown opcodes, counts retires.
module multicycle_controller
    import rv32i_pkg::*;
#(
    parameter int unsigned INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 alu_eq,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [3:0]           alu_op,
    output logic [1:0]           result_src,
    output logic [2:0]           imm_sel,
    output logic                 illegal,
    output logic [3:0]           state_check,
    output logic [INSTRET_W-1:0] instret
);

    mc_state_t  state;
    logic       is_rtype;
    logic [3:0] dec_alu_op;
    logic       retire;

    assign is_rtype    = (opcode == OP_R);
    assign state_check = state;

    mc_alu_decoder u_alu_decoder (
        .funct3   (funct3),
        .funct7   (funct7),
        .is_rtype (is_rtype),
        .alu_op   (dec_alu_op)
    );

    // Every path back to FETCH other than reset retires an instruction.
    always_comb begin
        retire = 1'b0;
        case (state)
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_JALR_LINK: retire = 1'b1;
            S_MEM_WRITE:                               retire = mem_ready;
            default:                                   retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            illegal <= 1'b0;
            instret <= '0;
        end else begin
            case (state)
                S_FETCH:     if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state <= S_MEM_ADDR;
                        OP_R:              state <= S_EXEC_R;
                        OP_I:              state <= S_EXEC_I;
                        OP_LUI:            state <= S_LUI;
                        OP_JAL:            state <= S_JAL;
                        OP_JALR:           state <= S_JALR;
                        OP_BRANCH:         state <= S_BRANCH;
                        default: begin
                            state   <= S_TRAP;
                            illegal <= 1'b1;
                        end
                    endcase
                end
                S_MEM_ADDR:  state <= (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
                S_MEM_READ:  if (mem_ready) state <= S_MEM_WB;
                S_MEM_WRITE: if (mem_ready) state <= S_FETCH;
                S_EXEC_R, S_EXEC_I, S_JAL, S_LUI: state <= S_ALU_WB;
                S_JALR:      state <= S_JALR_LINK;
                S_MEM_WB, S_ALU_WB, S_BRANCH, S_JALR_LINK: state <= S_FETCH;
                S_TRAP:      state <= S_TRAP;
                default:     state <= S_FETCH;
            endcase
            if (retire) instret <= instret + INSTRET_W'(1);
        end
    end

    // Datapath controls are pure decodes of the state, qualified by IR fields,
    // the memory handshake (FETCH) and the ALU compare flag (BRANCH).
    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_ADD;
        result_src = RES_ALUOUT;
        imm_sel    = IMM_I;
        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                imm_sel   = (opcode == OP_JAL) ? IMM_J : IMM_B;
            end
            S_MEM_ADDR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                imm_sel   = (opcode == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEM_READ: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEM_WB: begin
                result_src = RES_MEMDATA;
                reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_op    = dec_alu_op;
            end
            S_EXEC_I: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = dec_alu_op;
                imm_sel   = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SHAMT : IMM_I;
            end
            S_ALU_WB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                result_src = RES_ALUOUT;
                alu_src_a  = SRC_A_OLD_PC;
                alu_src_b  = SRC_B_FOUR;
            end
            S_BRANCH: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_RS2;
                alu_op     = ALU_SUB;
                result_src = RES_ALUOUT;
                pc_write   = ((funct3 == 3'b000) && alu_eq) || ((funct3 == 3'b001) && !alu_eq);
            end
            S_LUI: begin
                alu_src_b = SRC_B_IMM;
                imm_sel   = IMM_U;
                alu_op    = ALU_BPASS;
            end
            S_JALR: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                imm_sel    = IMM_I;
                result_src = RES_ALU;
                pc_write   = 1'b1;
            end
            S_JALR_LINK: begin
                alu_src_a  = SRC_A_OLD_PC;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                reg_write  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
